// File: rtl/clock_mode_sequencer_pkg.sv
// Shared definitions for the clock mode sequencer and the counter blocks
// that sit beside it: state index constants, default timing constants and
// the index-to-one-hot helper used for the mode_sel output.
package clock_pkg;

  // State index of the NORMAL (time-keeping) mode.
  localparam int IDX_NORMAL = 0;

  // Default configuration, shared with the time-counter/display blocks.
  localparam int DEF_NUM_FIELDS      = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 1000;

  // Widest one-hot vector the helper can produce (NUM_FIELDS + 1 <= this).
  localparam int MAX_STATES = 32;

  // Electrical level of an active-low push-button.
  typedef enum logic {
    BTN_PRESSED  = 1'b0,
    BTN_RELEASED = 1'b1
  } btn_level_e;

  // One-hot code of a state index; callers truncate to NUM_FIELDS+1 bits.
  function automatic logic [MAX_STATES-1:0] onehot_of_idx(input int unsigned idx);
    return MAX_STATES'(1) << idx;
  endfunction

endpackage

// File: rtl/clock_mode_sequencer_if.sv
// Button inputs and mode outputs of the clock mode sequencer.
// master = the side that drives the buttons and consumes the mode outputs,
// slave  = the sequencer itself.
interface clock_mode_sequencer_if #(
  parameter int NUM_FIELDS = 3
);
  localparam int IDX_W = $clog2(NUM_FIELDS + 1);

  logic                  mode_n;
  logic                  adjust_n;
  logic [NUM_FIELDS:0]   mode_sel;
  logic [IDX_W-1:0]      field_idx;
  logic                  inc_pulse;
  logic                  timeout;

  modport master (
    output mode_n,
    output adjust_n,
    input  mode_sel,
    input  field_idx,
    input  inc_pulse,
    input  timeout
  );

  modport slave (
    input  mode_n,
    input  adjust_n,
    output mode_sel,
    output field_idx,
    output inc_pulse,
    output timeout
  );
endinterface

// File: rtl/clock_mode_sequencer_button_debounce.sv
// button_debounce: 2-FF synchroniser plus level debouncer for one
// active-low push-button. Emits a one-cycle press pulse on each accepted
// released->pressed transition. After reset the button must be seen
// released before a press is reported, so a button held through reset
// needs a release and a fresh press.
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [1:0]       flush_q, flush_d;
  logic             armed_q, armed_d;

  // Register the synchroniser, debounce counter, accepted level and press pulse
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_q  <= {BTN_RELEASED, BTN_RELEASED};
      cnt_q   <= '0;
      level_q <= BTN_RELEASED;
      press_q <= 1'b0;
      flush_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
    end
  end

  // Count consecutive cycles of disagreement and accept the new level once
  // the count has reached DEBOUNCE_CYCLES; any return to the current level
  // restarts the count. flush_q marks when the synchroniser holds real pin
  // samples rather than its reset value, and only then can the button arm.
  always_comb begin
    sync_d  = {sync_q[0], btn_n};
    cnt_d   = cnt_q;
    level_d = level_q;
    flush_d = {flush_q[0], 1'b1};
    armed_d = armed_q;

    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_DONE) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush_q[1] && (sync_q[1] == BTN_RELEASED) && (level_q == BTN_RELEASED)) begin
      armed_d = 1'b1;
    end

    press_d = armed_q && (level_q == BTN_RELEASED) && (level_d == BTN_PRESSED);
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/clock_mode_sequencer.sv
// clock_mode_sequencer: mode controller for the digital clock.
// Steps NORMAL -> FIELD_1 .. FIELD_N -> NORMAL on debounced MODE presses and
// issues one-cycle increment pulses for the selected field on ADJUST presses.
// Optional feature macro: MODE_TIMEOUT_EN -- adds an idle counter that
// returns a setup state to NORMAL after TIMEOUT_CYCLES idle cycles and
// pulses timeout. Without it, timeout is tied low.
module clock_mode_sequencer
  import clock_pkg::*;
#(
  parameter int NUM_FIELDS      = DEF_NUM_FIELDS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input logic                   CLK,
  input logic                   reset,
  clock_mode_sequencer_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_FIELDS + 1);
  localparam int               STATES   = NUM_FIELDS + 1;
  localparam logic [IDX_W-1:0] IDX_NORM = IDX_W'(IDX_NORMAL);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FIELDS);

  logic               mode_level, mode_press;
  logic               adj_level, adj_press;
  logic               unused_levels;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STATES-1:0]  mode_sel_q, mode_sel_d;
  logic               inc_q, inc_d;
  logic               timeout_q, timeout_d;
  logic               timeout_hit;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_mode_db (
    .CLK   (CLK),
    .reset (reset),
    .btn_n (bus.mode_n),
    .level (mode_level),
    .press (mode_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_adjust_db (
    .CLK   (CLK),
    .reset (reset),
    .btn_n (bus.adjust_n),
    .level (adj_level),
    .press (adj_press)
  );

  // Debounced levels are not needed here; only the press events drive the FSM.
  assign unused_levels = mode_level ^ adj_level;

`ifdef MODE_TIMEOUT_EN
  localparam int               IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              any_press;

  assign any_press = mode_press | adj_press;

  // Idle counter register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Count idle cycles in a setup state; a press in the expiry cycle wins.
  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if (any_press || (idx_q == IDX_NORM)) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d      = '0;
      timeout_hit = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  // State register together with the registered mode outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idx_q      <= IDX_NORM;
      mode_sel_q <= STATES'(onehot_of_idx(32'(IDX_NORMAL)));
      inc_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      mode_sel_q <= mode_sel_d;
      inc_q      <= inc_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state: MODE advances with wrap, otherwise an expired idle count returns to NORMAL
  always_comb begin
    idx_d = idx_q;
    if (mode_press) begin
      idx_d = (idx_q == IDX_LAST) ? IDX_NORM : idx_q + 1'b1;
    end else if (timeout_hit) begin
      idx_d = IDX_NORM;
    end
  end

  // Outputs: one-hot follows the next index; ADJUST only counts in a setup state and loses to MODE
  always_comb begin
    mode_sel_d = STATES'(onehot_of_idx(32'(idx_d)));
    inc_d      = adj_press && !mode_press && (idx_q != IDX_NORM);
    timeout_d  = timeout_hit;
  end

  assign bus.mode_sel  = mode_sel_q;
  assign bus.field_idx = idx_q;
  assign bus.inc_pulse = inc_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Testbench for clock_mode_sequencer (NUM_FIELDS=3, DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=20). The reference model schedules each clean press to take
// effect DEBOUNCE_CYCLES+3 edges after the first edge that samples the pin low,
// then applies the mode/adjust/timeout rules to a plain integer state index.
module tb_clock_mode_sequencer;

  localparam int N    = 3;
  localparam int D    = 4;
  localparam int T    = 20;
  localparam int LAT  = D + 3;
  localparam int MAXE = 16384;

  logic CLK;
  logic reset;

  clock_mode_sequencer_if #(.NUM_FIELDS(N)) bus ();

  clock_mode_sequencer #(
    .NUM_FIELDS      (N),
    .DEBOUNCE_CYCLES (D),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total     = 0;
  int bad       = 0;
  int edge_no   = 0;
  int m_idx     = 0;
  int m_idle    = 0;
  bit m_inc     = 1'b0;
  bit m_to      = 1'b0;
  int inc_seen  = 0;
  int to_seen   = 0;
  bit mode_ev [MAXE];
  bit adj_ev  [MAXE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    bit mp;
    bit ap;
    mp    = mode_ev[edge_no];
    ap    = adj_ev[edge_no];
    m_inc = 1'b0;
    m_to  = 1'b0;
    if (mp) m_idx = (m_idx == N) ? 0 : m_idx + 1;
    else if (ap && m_idx != 0) m_inc = 1'b1;
`ifdef MODE_TIMEOUT_EN
    if (mp || ap) m_idle = 0;
    else if (m_idx == 0) m_idle = 0;
    else if (m_idle == T - 1) begin
      m_idx  = 0;
      m_to   = 1'b1;
      m_idle = 0;
    end else m_idle++;
`endif
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_idle = 0;
    m_inc  = 1'b0;
    m_to   = 1'b0;
    for (int e = edge_no; e < MAXE; e++) begin
      mode_ev[e] = 1'b0;
      adj_ev[e]  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [N:0] exp_sel;
    exp_sel = (N + 1)'(1) << m_idx;
    chk("mode_sel",  32'(bus.mode_sel),  32'(exp_sel));
    chk("field_idx", 32'(bus.field_idx), 32'(m_idx));
    chk("inc_pulse", 32'(bus.inc_pulse), 32'(m_inc));
    chk("timeout",   32'(bus.timeout),   32'(m_to));
    inc_seen += int'(bus.inc_pulse);
    to_seen  += int'(bus.timeout);
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge CLK);
    edge_no++;
    if (!reset) model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  function automatic int ev_edge();
    return edge_no + 1 + LAT;
  endfunction

  // Clean press of mode and/or adjust: low for hold cycles, then high for gap cycles.
  task automatic press(input bit m, input bit a, input int hold, input int gap);
    if (m) begin
      bus.mode_n = 1'b0;
      if (ev_edge() < MAXE) mode_ev[ev_edge()] = 1'b1;
    end
    if (a) begin
      bus.adjust_n = 1'b0;
      if (ev_edge() < MAXE) adj_ev[ev_edge()] = 1'b1;
    end
    repeat (hold) tick();
    bus.mode_n   = 1'b1;
    bus.adjust_n = 1'b1;
    repeat (gap) tick();
  endtask

  logic [N:0] step_exp [4];
  int s;
  int s_to;
  int op;

  initial begin
    step_exp[0] = 4'b0010;
    step_exp[1] = 4'b0100;
    step_exp[2] = 4'b1000;
    step_exp[3] = 4'b0001;

    reset        = 1'b1;
    bus.mode_n   = 1'b1;
    bus.adjust_n = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: NORMAL, no pulses
    repeat (100) tick();
    chk("idle_sel", 32'(bus.mode_sel), 32'h1);
    chk("idle_idx", 32'(bus.field_idx), 32'h0);
    chk("idle_inc_count", inc_seen, 0);
    chk("idle_to_count", to_seen, 0);

    // First mode press with explicit latency checks around press-edge+7
    bus.mode_n = 1'b0;
    mode_ev[ev_edge()] = 1'b1;
    repeat (LAT) tick();
    chk("lat_before", 32'(bus.mode_sel), 32'h1);
    tick();
    chk("lat_at", 32'(bus.mode_sel), 32'h2);
    repeat (10 - LAT - 1) tick();
    bus.mode_n = 1'b1;
    repeat (10) tick();
    chk("step_sel0", 32'(bus.mode_sel), 32'(step_exp[0]));
    for (int i = 1; i < 4; i++) begin
      press(1'b1, 1'b0, 10, 10);
      chk("step_sel", 32'(bus.mode_sel), 32'(step_exp[i]));
    end

    // Short glitch is filtered
    bus.mode_n = 1'b0;
    repeat (3) tick();
    bus.mode_n = 1'b1;
    repeat (12) tick();
    chk("glitch_idx", 32'(bus.field_idx), 32'h0);

    // Adjust in NORMAL is ignored
    s = inc_seen;
    press(1'b0, 1'b1, 8, 10);
    chk("adj_normal_inc", inc_seen - s, 0);

    // Bounce 0/1/0 then steady low: one step
    bus.mode_n = 1'b0;
    tick();
    bus.mode_n = 1'b1;
    tick();
    bus.mode_n = 1'b0;
    mode_ev[ev_edge()] = 1'b1;
    repeat (8) tick();
    bus.mode_n = 1'b1;
    repeat (8) tick();
    chk("bounce_idx", 32'(bus.field_idx), 32'h1);

    // FIELD_2: three adjust presses
    press(1'b1, 1'b0, 6, 8);
    chk("field2_idx", 32'(bus.field_idx), 32'h2);
    s = inc_seen;
    repeat (3) press(1'b0, 1'b1, 6, 8);
    chk("adj_inc_count", inc_seen - s, 3);
    chk("adj_idx_kept", 32'(bus.field_idx), 32'h2);

    // Back round to FIELD_1, then simultaneous mode+adjust
    repeat (3) press(1'b1, 1'b0, 6, 8);
    chk("field1_idx", 32'(bus.field_idx), 32'h1);
    s = inc_seen;
    press(1'b1, 1'b1, 6, 8);
    chk("both_idx", 32'(bus.field_idx), 32'h2);
    chk("both_inc", inc_seen - s, 0);

    // Long idle in a setup state
    s_to = to_seen;
    repeat (30) tick();
`ifdef MODE_TIMEOUT_EN
    chk("to_count_a", to_seen - s_to, 1);
    chk("to_sel_a", 32'(bus.mode_sel), 32'h1);
    press(1'b1, 1'b0, 6, 8);
    s_to = to_seen;
    repeat (25) tick();
    chk("to_count_f1", to_seen - s_to, 1);
    chk("to_sel_f1", 32'(bus.mode_sel), 32'h1);
`else
    chk("persist_to", to_seen - s_to, 0);
    chk("persist_sel", 32'(bus.mode_sel), 32'h4);
`endif

    // Reset in the middle of a debounce while in a setup state
    press(1'b1, 1'b0, 6, 8);
    chk("pre_reset_setup", 32'(bus.field_idx != 0), 32'h1);
    bus.mode_n = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_sel", 32'(bus.mode_sel), 32'h1);
    chk("rst_async_idx", 32'(bus.field_idx), 32'h0);
    chk("rst_async_inc", 32'(bus.inc_pulse), 32'h0);
    chk("rst_async_to", 32'(bus.timeout), 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("held_no_event", 32'(bus.field_idx), 32'h0);
    bus.mode_n = 1'b1;
    repeat (12) tick();
    press(1'b1, 1'b0, 6, 8);
    chk("rearm_idx", 32'(bus.field_idx), 32'h1);

    // Randomised clean presses, glitches and idle stretches
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: press(1'b1, 1'b0, int'($urandom_range(6, 12)), int'($urandom_range(8, 12)));
        1: press(1'b0, 1'b1, int'($urandom_range(6, 12)), int'($urandom_range(8, 12)));
        2: press(1'b1, 1'b1, int'($urandom_range(6, 12)), int'($urandom_range(8, 12)));
        3: begin
          bus.mode_n = 1'b0;
          repeat (int'($urandom_range(1, 3))) tick();
          bus.mode_n = 1'b1;
          repeat (int'($urandom_range(8, 12))) tick();
        end
        default: repeat (int'($urandom_range(1, 30))) tick();
      endcase
    end
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
